// File: rtl/rv_test_monitor_if.sv
// Register-file writeback snoop bundle between the core's write port and the test monitor.
interface rv_test_monitor_if #(
    parameter int XLEN = 32
);
    logic            wb_we_i;
    logic [4:0]      wb_waddr_i;
    logic [XLEN-1:0] wb_wdata_i;

    modport master (output wb_we_i, wb_waddr_i, wb_wdata_i);
    modport slave  (input  wb_we_i, wb_waddr_i, wb_wdata_i);
endinterface

// File: rtl/rv_test_monitor.sv
// Pass/fail monitor for rv32ui self-tests: shadows done/pass/test-number registers off the writeback port.
// Optional macro TEST_MON_FAILNUM_EN builds the test-number shadow and drives fail_num_o.
module rv_test_monitor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DONE_REG    = 26,
    parameter int unsigned PASS_REG    = 27,
    parameter int unsigned NUM_REG     = 3,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    rv_test_monitor_if.slave     wb,
    output logic                 test_done_o,
    output logic                 test_pass_o,
    output logic                 test_fail_o,
    output logic                 test_timeout_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [CNT_W-1:0]     wr_cnt_o,
    output logic [XLEN-1:0]      fail_num_o
);
    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_SETTLE,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic             WD_EN     = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [XLEN-1:0]   pass_sh_q, pass_sh_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
`ifdef TEST_MON_FAILNUM_EN
    logic [XLEN-1:0]   num_sh_q, num_sh_d;
    logic [XLEN-1:0]   fail_num_q, fail_num_d;
`endif

    logic wr_valid;
    logic done_hit;
    logic wd_expire;

    // x0 writes are invisible: no shadow update and no write count.
    assign wr_valid  = wb.wb_we_i && (wb.wb_waddr_i != 5'd0);
    assign done_hit  = wr_valid && (wb.wb_waddr_i == 5'(DONE_REG)) && (wb.wb_wdata_i != '0);
    assign wd_expire = WD_EN && (cycle_cnt_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cycle_cnt_d = cycle_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        pass_sh_d   = pass_sh_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
`ifdef TEST_MON_FAILNUM_EN
        num_sh_d    = num_sh_q;
        fail_num_d  = fail_num_q;
        if (wr_valid && (wb.wb_waddr_i == 5'(NUM_REG)))
            num_sh_d = wb.wb_wdata_i;
`endif
        if (wr_valid && (wb.wb_waddr_i == 5'(PASS_REG)))
            pass_sh_d = wb.wb_wdata_i;

        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (wr_valid)
                    wr_cnt_d = sat_inc(wr_cnt_q);
                // A done write on the watchdog's last cycle still counts as a finished test.
                if (done_hit) begin
                    state_d     = ST_SETTLE;
                    settle_d    = SETTLE_LD;
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                end else if (wd_expire) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
`ifdef TEST_MON_FAILNUM_EN
                    fail_num_d = num_sh_q;
`endif
                end else begin
                    cycle_cnt_d = sat_inc(cycle_cnt_q);
                end
            end
            ST_SETTLE: begin
                if (settle_q == 8'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (pass_sh_q == XLEN'(1));
                    fail_d  = (pass_sh_q != XLEN'(1));
`ifdef TEST_MON_FAILNUM_EN
                    if (pass_sh_q != XLEN'(1))
                        fail_num_d = num_sh_q;
`endif
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            settle_q    <= '0;
            cycle_cnt_q <= '0;
            wr_cnt_q    <= '0;
            pass_sh_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef TEST_MON_FAILNUM_EN
            num_sh_q    <= '0;
            fail_num_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            cycle_cnt_q <= cycle_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            pass_sh_q   <= pass_sh_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
`ifdef TEST_MON_FAILNUM_EN
            num_sh_q    <= num_sh_d;
            fail_num_q  <= fail_num_d;
`endif
        end
    end

    assign test_done_o    = done_q;
    assign test_pass_o    = pass_q;
    assign test_fail_o    = fail_q;
    assign test_timeout_o = timeout_q;
    assign cycle_cnt_o    = cycle_cnt_q;
    assign wr_cnt_o       = wr_cnt_q;
`ifdef TEST_MON_FAILNUM_EN
    assign fail_num_o     = fail_num_q;
`else
    assign fail_num_o     = '0;
`endif
endmodule
